// File: rtl/randist_sched_pkg.sv
// Shared defaults and types for the randist request scheduler.
package randist_sched_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned IDW_DEF   = 2;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned CW_DEF    = 5;

  // IEEE-754 double 1.0
  localparam logic [63:0] ONE = 64'h3FF0_0000_0000_0000;

  // One returned sample tagged with the requester that owns it.
  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic [63:0]        z;
  } res_t;

endpackage

// File: rtl/randist_sched_fifo.sv
// Synchronous show-ahead FIFO; push and pop in the same cycle are legal at any fill level.
module rs_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             full, do_push, do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_push = push_i & (~full | do_pop);
  assign dout_o  = mem_q[rd_q];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_next(wr_q);
      if (do_pop)  rd_q <= ptr_next(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/randist_sched.sv
// Round-robin scheduler sharing one randist datapath among NREQ requesters,
// with credit-limited issue and id-tagged, buffered result return.
module randist_sched
  import randist_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned IDW   = IDW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic            u_valid,
  output logic            u_ready,
  input  logic [63:0]     u1,
  input  logic [63:0]     u2,
  output logic            dp_pushin,
  output logic [63:0]     dp_u1,
  output logic [63:0]     dp_u2,
  input  logic            dp_pushout,
  input  logic [63:0]     dp_z,
  output logic            zout_valid,
  input  logic            zout_ready,
  output logic [63:0]     zout,
  output logic [IDW-1:0]  zout_id,
  output logic [CW-1:0]   outstanding,
  output logic            err
);

  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] sel_idx;
  logic           any_req;
  int unsigned    cand;
  logic           issue;
  logic [CW-1:0]  out_q;
  logic           err_q, pushin_q;
  logic [63:0]    u1_q, u2_q;

  logic [IDW-1:0] tag_head;
  logic           tag_empty;
  logic           res_push, res_empty, out_pop;
  res_t           res_in, res_head;

  // Round-robin search upward from the slot after the last grant.
  always_comb begin
    sel_idx = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_q) + k) % NREQ;
      if (!any_req && req[cand[IDW-1:0]]) begin
        any_req = 1'b1;
        sel_idx = cand[IDW-1:0];
      end
    end
  end

  assign issue   = ~rst & en & any_req & u_valid & (out_q < CW'(DEPTH));
  assign u_ready = issue;

  // One-hot grant for the selected requester on an issue cycle.
  always_comb begin
    gnt = '0;
    if (issue) gnt[sel_idx] = 1'b1;
  end

  assign out_pop  = ~res_empty & zout_ready;
  assign res_push = dp_pushout & ~tag_empty;
  assign res_in   = '{id: tag_head, z: dp_z};

  rs_fifo #(.WIDTH(IDW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (issue),
    .din_i   (sel_idx),
    .pop_i   (dp_pushout),
    .dout_o  (tag_head),
    .empty_o (tag_empty)
  );

  rs_fifo #(.WIDTH($bits(res_t)), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (res_push),
    .din_i   (res_in),
    .pop_i   (out_pop),
    .dout_o  (res_head),
    .empty_o (res_empty)
  );

  // Arbitration pointer, datapath launch registers, credits and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= IDW'(NREQ - 1);
      pushin_q <= 1'b0;
      u1_q     <= '0;
      u2_q     <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      pushin_q <= issue;
      if (issue) begin
        rr_q <= sel_idx;
        u1_q <= u1;
        u2_q <= u2;
      end
      case ({issue, out_pop})
        2'b10:   out_q <= out_q + 1'b1;
        2'b01:   out_q <= out_q - 1'b1;
        default: out_q <= out_q;
      endcase
      if (dp_pushout && tag_empty) err_q <= 1'b1;
    end
  end

  assign dp_pushin   = pushin_q;
  assign dp_u1       = u1_q;
  assign dp_u2       = u2_q;
  assign zout_valid  = ~res_empty;
  assign zout        = res_head.z;
  assign zout_id     = res_head.id;
  assign outstanding = out_q;
  assign err         = err_q;

endmodule

// File: tb/tb_randist_sched.sv
// Self-checking bench for randist_sched with a stand-in fixed-latency datapath.
module tb_randist_sched;
  import randist_sched_pkg::*;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst, en, u_valid, zout_ready, dp_pushout, dp_pushin, u_ready;
  logic        zout_valid, err, force_po;
  logic [3:0]  req, gnt;
  logic [63:0] u1, u2, dp_u1, dp_u2, dp_z, zout;
  logic [1:0]  zout_id;
  logic [4:0]  outstanding;

  always #5 clk = ~clk;

  randist_sched dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .gnt(gnt),
    .u_valid(u_valid), .u_ready(u_ready), .u1(u1), .u2(u2),
    .dp_pushin(dp_pushin), .dp_u1(dp_u1), .dp_u2(dp_u2),
    .dp_pushout(dp_pushout), .dp_z(dp_z),
    .zout_valid(zout_valid), .zout_ready(zout_ready), .zout(zout),
    .zout_id(zout_id), .outstanding(outstanding), .err(err)
  );

  // Stand-in randist: L-stage in-order pipe applying a fixed mixing function.
  function automatic logic [63:0] zfun(input logic [63:0] a, input logic [63:0] b);
    return a ^ {b[31:0], b[63:32]} ^ 64'h0000_0000_0000_0001;
  endfunction

  logic [L-1:0] pv;
  logic [63:0]  pz [L];
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else begin
      pv    <= {pv[L-2:0], dp_pushin};
      pz[0] <= zfun(dp_u1, dp_u2);
      for (int i = 1; i < L; i++) pz[i] <= pz[i-1];
    end
  end
  assign dp_pushout = pv[L-1] | force_po;
  assign dp_z       = pz[L-1];

  // Reference model state.
  typedef struct {
    logic [1:0]  id;
    logic [63:0] z;
    int          rdy;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0, cyc = 0, out_m = 0, last_m = 3, nissue = 0;
  logic        err_m = 1'b0, dpv_m = 1'b0;
  logic [63:0] dpu1_m = '0, dpu2_m = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle: drive, check against the model mid-cycle, advance model, check registers.
  task automatic step(input logic e, input logic [3:0] r, input logic uv, input logic zr,
                      input logic [63:0] a, input logic [63:0] b);
    logic       exp_issue, exp_valid;
    logic [3:0] exp_gnt;
    int         id;
    en = e; req = r; u_valid = uv; zout_ready = zr; u1 = a; u2 = b;
    #4;
    exp_issue = e && (r != 4'b0) && uv && (out_m < 16);
    exp_gnt   = 4'b0;
    id        = 0;
    if (exp_issue) begin
      for (int k = 1; k <= 4; k++) begin
        if (exp_gnt == 4'b0 && r[(last_m + k) % 4]) begin
          id = (last_m + k) % 4;
          exp_gnt[id] = 1'b1;
        end
      end
    end
    chk("gnt", gnt, exp_gnt);
    chk("u_ready", u_ready, exp_issue);
    exp_valid = (sb.size() > 0) && (sb[0].rdy <= cyc);
    chk("zout_valid", zout_valid, exp_valid);
    if (exp_valid) begin
      chk("zout", zout, sb[0].z);
      chk("zout_id", zout_id, sb[0].id);
    end
    chk("outstanding", outstanding, out_m);
    chk("err", err, err_m);
    if (exp_valid && zr) begin
      void'(sb.pop_front());
      out_m--;
    end
    dpv_m = exp_issue;
    if (exp_issue) begin
      sb.push_back('{id: 2'(id), z: zfun(a, b), rdy: cyc + L + 2});
      last_m = id;
      out_m++;
      nissue++;
      dpu1_m = a;
      dpu2_m = b;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("dp_pushin", dp_pushin, dpv_m);
    chk("dp_u1", dp_u1, dpu1_m);
    chk("dp_u2", dp_u2, dpu2_m);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = '0; u_valid = 1'b0; zout_ready = 1'b0; force_po = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_u_ready", u_ready, 1'b0);
    chk("rst_dp_pushin", dp_pushin, 1'b0);
    chk("rst_dp_u1", dp_u1, 64'h0);
    chk("rst_dp_u2", dp_u2, 64'h0);
    chk("rst_zout_valid", zout_valid, 1'b0);
    chk("rst_outstanding", outstanding, 5'd0);
    chk("rst_err", err, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    sb.delete();
    out_m = 0; last_m = 3; err_m = 1'b0; dpv_m = 1'b0; dpu1_m = '0; dpu2_m = '0;
  endtask

  initial begin
    force_po = 1'b0; u1 = '0; u2 = '0;
    #1;
    do_reset();

    // Single request from requester 2, then drain and see the credit return to 0.
    step(1, 4'b0100, 1, 1, 64'h3FE0_0000_0000_0000, 64'h3FD0_0000_0000_0000);
    for (int i = 0; i < 8; i++) step(1, 4'b0000, 1, 1, r64(), r64());
    chk("single_drained", outstanding, 5'd0);

    // Round-robin over all four requesters from a fresh pointer.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 4'b1111, 1, 0, r64(), r64());
    for (int i = 0; i < 10; i++) step(1, 4'b0000, 0, 1, r64(), r64());

    // Credit full: 20 requests with no consumer yield exactly 16 issues.
    do_reset();
    nissue = 0;
    for (int i = 0; i < 20; i++) step(1, 4'($urandom_range(1, 15)), 1, 0, r64(), r64());
    chk("full_issues", nissue, 16);
    chk("full_outstanding", outstanding, 5'd16);
    step(1, 4'b1111, 1, 1, r64(), r64());
    step(1, 4'b1111, 1, 0, r64(), r64());
    chk("refill_issues", nissue, 17);

    // Simultaneous pop and issue at the credit limit.
    for (int i = 0; i < 12; i++) step(1, 4'b1111, 1, 1, ONE, r64());

    // Gating by en and u_valid while the backlog drains.
    for (int i = 0; i < 10; i++) step(0, 4'b1111, 1, 1, r64(), r64());
    for (int i = 0; i < 10; i++) step(1, 4'b1111, 0, 1, r64(), r64());

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 7) != 0), 4'($urandom), ($urandom_range(0, 5) != 0),
           1'($urandom), r64(), r64());
    for (int i = 0; i < 30; i++) step(0, 4'b0000, 0, 1, r64(), r64());
    chk("random_drained", outstanding, 5'd0);

    // Reset with five results in flight: nothing stale afterwards.
    for (int i = 0; i < 5; i++) step(1, 4'b1111, 1, 0, r64(), r64());
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 4'b0000, 0, 1, r64(), r64());

    // Spurious datapath result with the tag FIFO empty sets the sticky error.
    force_po = 1'b1;
    step(0, 4'b0000, 0, 1, r64(), r64());
    force_po = 1'b0;
    err_m = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 4'b0001, 1, 1, r64(), r64());
    for (int i = 0; i < 8; i++) step(0, 4'b0000, 0, 1, r64(), r64());
    do_reset();
    step(0, 4'b0000, 0, 1, r64(), r64());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
